// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receive controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Controller state: receiver gated off, or running and accepting bytes.
  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  localparam int NBITS           = 8;   // data bits per frame
  localparam int OS_RATE         = 16;  // oversample ticks per bit period
  localparam int CLK_DIV_DEFAULT = 27;  // clk cycles per oversample tick

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: counts 0..CLK_DIV-1 while enabled, strobes on the wrap cycle.
// Latency: first tick CLK_DIV cycles after en rises; clr zeroes the count on the next edge.
// Backpressure: none; the tick is a free-running strobe with no handshake.
// Ports: clk, rst_n (sync, active-low), en (count enable), clr (sync clear), tick (1-cycle strobe).
module uart_baud_gen #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Decoded from registered state only, so the strobe is clean and drops
  // in the same cycle the enable goes away (no partial tick on exit).
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: run/off gating, oversample tick generation, byte FIFO with sticky error flags.
// Latency: pop -> rd_data/rd_valid next cycle; push visible in count next cycle; no push->pop bypass.
// Backpressure: none toward the shifter; bytes arriving while full (and not popped) drop and set overrun.
// Ports: clk, rst_n | en, flush, clr_err | rx_done, rx_byte, rx_stop_bad | os_tick, rx_enable
//        rd_en, rd_data, rd_valid | empty, full, count | overrun, frame_err
import uart_pkg::*;

module uart_rx_ctrl #(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              rx_done,
  input  logic [NBITS-1:0]  rx_byte,
  input  logic              rx_stop_bad,
  output logic              os_tick,
  output logic              rx_enable,
  input  logic              rd_en,
  output logic [NBITS-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t state;
  logic   run;

  // ---------------- run/off FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      rx_enable <= 1'b0;
    end else begin
      case (state)
        ST_OFF: if (en) begin
          state     <= ST_RUN;
          rx_enable <= 1'b1;
        end
        ST_RUN: if (!en) begin
          state     <= ST_OFF;
          rx_enable <= 1'b0;
        end
        default: begin
          state     <= ST_OFF;
          rx_enable <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state == ST_RUN);

  // Divider is held in clear whenever we are not running, so re-entering
  // RUN always starts a fresh CLK_DIV-cycle period.
  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (!run),
    .tick  (os_tick)
  );

  // ---------------- FIFO ----------------
  logic [NBITS-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic wr_attempt;
  logic do_pop;
  logic do_push;
  logic frame_set;
  logic ovr_set;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Pop decision is based on current occupancy only: a byte pushed this
  // cycle cannot be popped this cycle.
  assign do_pop     = rd_en && !empty && !flush;
  assign wr_attempt = run && rx_done;
  assign frame_set  = wr_attempt && rx_stop_bad;
  assign ovr_set    = wr_attempt && !rx_stop_bad && full && !rd_en;
  // A same-cycle pop frees the slot a full FIFO needs for this push.
  assign do_push    = wr_attempt && !rx_stop_bad && (!full || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- sticky status ----------------
  // A set event in the same cycle as clr_err wins, so no error is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic            rx_done;
  logic [7:0]      rx_byte;
  logic            rx_stop_bad;
  logic            os_tick;
  logic            rx_enable;
  logic            rd_en;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overrun;
  logic            frame_err;
  logic            clr_err;

  uart_rx_ctrl #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .flush       (flush),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .rx_stop_bad (rx_stop_bad),
    .os_tick     (os_tick),
    .rx_enable   (rx_enable),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clr_err     (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  bit         m_run;
  int         m_runcyc;   // cycles spent in RUN since entering it
  logic [7:0] m_rd_data;
  bit         m_rdv;
  bit         m_ovr;
  bit         m_fe;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run     = 1'b0;
    m_runcyc  = 0;
    m_rd_data = 8'h00;
    m_rdv     = 1'b0;
    m_ovr     = 1'b0;
    m_fe      = 1'b0;
  endtask

  task automatic model_step();
    int sz;
    bit pop, att, push, fe_set, ov_set;
    if (!rst_n) begin
      model_reset();
    end else begin
      sz     = q.size();
      pop    = rd_en && (sz > 0) && !flush;
      att    = m_run && rx_done;
      fe_set = att && rx_stop_bad;
      ov_set = att && !rx_stop_bad && (sz == DEPTH) && !rd_en;
      push   = att && !rx_stop_bad && ((sz < DEPTH) || pop) && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (pop)  m_rd_data = q.pop_front();
        if (push) q.push_back(rx_byte);
      end
      m_rdv = pop;
      if (ov_set)       m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
      if (fe_set)       m_fe = 1'b1;
      else if (clr_err) m_fe = 1'b0;
      if (en) m_runcyc = m_run ? m_runcyc + 1 : 1;
      else    m_runcyc = 0;
      m_run = en;
    end
  endtask

  task automatic compare_all();
    check("os_tick",   32'(os_tick),   32'(m_run && (m_runcyc % CLK_DIV == 0)));
    check("rx_enable", 32'(rx_enable), 32'(m_run));
    check("count",     32'(count),     32'(q.size()));
    check("empty",     32'(empty),     32'(q.size() == 0));
    check("full",      32'(full),      32'(q.size() == DEPTH));
    check("rd_valid",  32'(rd_valid),  32'(m_rdv));
    check("rd_data",   32'(rd_data),   32'(m_rd_data));
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("frame_err", 32'(frame_err), 32'(m_fe));
  endtask

  // One clock: inputs are stable from the previous negedge, the model follows
  // the edge, outputs are compared at the following negedge, pulses drop.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    rx_done     = 1'b0;
    rx_stop_bad = 1'b0;
    rd_en       = 1'b0;
    flush       = 1'b0;
    clr_err     = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_byte = b;
    cycle();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; rx_done = 1'b0; rx_byte = 8'h00;
    rx_stop_bad = 1'b0; rd_en = 1'b0; clr_err = 1'b0;

    // ---- reset state ----
    cycle();
    cycle();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    cycle();

    // ---- 1: tick timing, en dropped mid-period ----
    en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 11) en = 1'b0;
      cycle();
      check("t1_tick", 32'(os_tick), 32'((k == 4) || (k == 8)));
    end

    // ---- 2: two bytes in, two out ----
    en = 1'b1;
    cycle();
    push_byte(8'hA5);
    push_byte(8'h3C);
    rd_en = 1'b1; cycle();
    check("t2_valid0", 32'(rd_valid), 32'd1);
    check("t2_data0",  32'(rd_data),  32'hA5);
    rd_en = 1'b1; cycle();
    check("t2_valid1", 32'(rd_valid), 32'd1);
    check("t2_data1",  32'(rd_data),  32'h3C);
    check("t2_empty",  32'(empty),    32'd1);

    // ---- 3: overfill, 17th byte dropped ----
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
    check("t3_full",  32'(full),    32'd1);
    check("t3_count", 32'(count),   32'd16);
    check("t3_ovr",   32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; cycle();
      check("t3_data", 32'(rd_data), 32'(8'h10 + i));
    end
    cycle();
    check("t3_empty", 32'(empty), 32'd1);

    // ---- 4: push+pop while full, through pointer wrap ----
    clr_err = 1'b1; cycle();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      rd_en = 1'b1;
      push_byte(8'(8'h80 + i));
      check("t4_count", 32'(count),   32'd16);
      check("t4_ovr",   32'(overrun), 32'd0);
      check("t4_data",  32'(rd_data), (i < 16) ? 32'(8'h40 + i) : 32'(8'h80 + i - 16));
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; cycle();
      check("t4_drain", 32'(rd_data), 32'(8'h80 + i + 4));
    end

    // ---- 5: framing error, clear, set-beats-clear ----
    rx_stop_bad = 1'b1; push_byte(8'hFF);
    check("t5_fe",    32'(frame_err), 32'd1);
    check("t5_count", 32'(count),     32'd0);
    clr_err = 1'b1; cycle();
    check("t5_clr",   32'(frame_err), 32'd0);
    rx_stop_bad = 1'b1; clr_err = 1'b1; push_byte(8'h11);
    check("t5_win",   32'(frame_err), 32'd1);
    clr_err = 1'b1; cycle();

    // ---- 6: flush, then reset mid-stream ----
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    check("t6_count5", 32'(count), 32'd5);
    flush = 1'b1; rd_en = 1'b1; push_byte(8'hEE);
    check("t6_flush_count", 32'(count),    32'd0);
    check("t6_flush_empty", 32'(empty),    32'd1);
    check("t6_flush_rdv",   32'(rd_valid), 32'd0);
    for (int i = 0; i < 3; i++) push_byte(8'(8'hD0 + i));
    rd_en = 1'b1; rst_n = 1'b0; push_byte(8'h77);
    check("t6_rst_count",  32'(count),     32'd0);
    check("t6_rst_empty",  32'(empty),     32'd1);
    check("t6_rst_rdv",    32'(rd_valid),  32'd0);
    check("t6_rst_rdd",    32'(rd_data),   32'h00);
    check("t6_rst_en",     32'(rx_enable), 32'd0);
    check("t6_rst_tick",   32'(os_tick),   32'd0);
    check("t6_rst_fe",     32'(frame_err), 32'd0);
    rst_n = 1'b1;
    cycle();

    // ---- random traffic against the model ----
    for (int n = 0; n < 800; n++) begin
      en          = ($urandom_range(0, 19) != 0);
      rx_done     = ($urandom_range(0, 2) == 0);
      rx_byte     = 8'($urandom);
      rx_stop_bad = rx_done && ($urandom_range(0, 9) == 0);
      rd_en       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 59) == 0);
      clr_err     = ($urandom_range(0, 24) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      cycle();
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
